pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage MIPS pipeline. Drives PC write-enable, IF/ID write-enable and the IF/ID and ID/EX flush lines: it inserts load-use bubbles, squashes wrong-path instructions on taken branches and jumps, and holds the front end while the multi-cycle multiply/divide unit is busy. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipeline_ctrl_pkg.sv | 16 +
 rtl/pipeline_ctrl_load_use.sv | 17 +
 rtl/pipeline_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the MIPS pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] PCSRC_NONE   = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_JR     = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Combinational load-use hazard compare between the load in EX and the sources of the ID instruction.
// A load to $zero never creates a hazard.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       ex_mem_rden_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       load_use_o
);

  assign load_use_o = ex_mem_rden_i && (ex_rt_i != REG_ZERO) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller: load-use bubbles, redirect squashes, multiply/divide front-end hold
// with a watchdog, and a saturating stall-cycle counter. Hazard outputs are combinational.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 40,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             ID_RS,
  input  logic [4:0]             ID_RT,
  input  logic                   ID_UsesRT,
  input  logic                   ID_MD,
  input  logic                   EX_MEM_RDEN,
  input  logic [4:0]             EX_RT,
  input  logic [1:0]             EX_PCSrc,
  input  logic                   MD_DONE,
  input  logic                   Stall_Clr,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Flush,
  output logic                   MD_Start,
  output logic                   MD_Busy,
  output logic                   MD_Error,
  output logic [STALL_CNT_W-1:0] Stall_Cycles
);

  localparam int WD_W = (MD_MAX_CYCLES > 2) ? $clog2(MD_MAX_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   busy_q, err_q, err_d;
  logic [STALL_CNT_W-1:0] stall_q;

  logic load_use, redirect;
  logic pc_w, ifid_w, ifid_fl, idex_fl, md_start;

  load_use_detect u_load_use (
    .ex_mem_rden_i (EX_MEM_RDEN),
    .ex_rt_i       (EX_RT),
    .id_rs_i       (ID_RS),
    .id_rt_i       (ID_RT),
    .id_uses_rt_i  (ID_UsesRT),
    .load_use_o    (load_use)
  );

  assign redirect = (EX_PCSrc != PCSRC_NONE);

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    err_d    = 1'b0;
    pc_w     = 1'b1;
    ifid_w   = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    md_start = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          ifid_fl = 1'b1;
          idex_fl = 1'b1;
        end else if (load_use) begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_fl = 1'b1;
        end else if (ID_MD) begin
          md_start = 1'b1;
          state_d  = MD_WAIT;
          wd_d     = '0;
        end
      end
      MD_WAIT: begin
        if (MD_DONE) begin
          state_d = RUN;
          if (redirect) begin
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
          end else if (load_use) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_fl = 1'b1;
          end
        end else begin
          wd_d = wd_q + 1'b1;
          // A redirect must still load the target PC even while the MD op is outstanding.
          if (redirect) begin
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
          end else begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_fl = 1'b1;
          end
          if (wd_q == WD_LAST) begin
            state_d = RUN;
            wd_d    = '0;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      busy_q  <= (state_d == MD_WAIT);
      err_q   <= err_d;
      if (Stall_Clr) begin
        stall_q <= '0;
      end else if (!pc_w && (stall_q != {STALL_CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  // Hold the front end and flush both pipeline registers for as long as reset is low.
  assign PC_Write     = reset & pc_w;
  assign IF_ID_Write  = reset & ifid_w;
  assign IF_ID_Flush  = ~reset | ifid_fl;
  assign ID_EX_Flush  = ~reset | idex_fl;
  assign MD_Start     = reset & md_start;
  assign MD_Busy      = busy_q;
  assign MD_Error     = err_q;
  assign Stall_Cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with a short (8-cycle) MD watchdog.
module tb_pipeline_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  ID_RS, ID_RT, EX_RT;
  logic        ID_UsesRT, ID_MD, EX_MEM_RDEN, MD_DONE, Stall_Clr;
  logic [1:0]  EX_PCSrc;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MD_Start, MD_Busy, MD_Error;
  logic [15:0] Stall_Cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pipeline_ctrl #(.MD_MAX_CYCLES(8), .STALL_CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .ID_RS        (ID_RS),
    .ID_RT        (ID_RT),
    .ID_UsesRT    (ID_UsesRT),
    .ID_MD        (ID_MD),
    .EX_MEM_RDEN  (EX_MEM_RDEN),
    .EX_RT        (EX_RT),
    .EX_PCSrc     (EX_PCSrc),
    .MD_DONE      (MD_DONE),
    .Stall_Clr    (Stall_Clr),
    .PC_Write     (PC_Write),
    .IF_ID_Write  (IF_ID_Write),
    .IF_ID_Flush  (IF_ID_Flush),
    .ID_EX_Flush  (ID_EX_Flush),
    .MD_Start     (MD_Start),
    .MD_Busy      (MD_Busy),
    .MD_Error     (MD_Error),
    .Stall_Cycles (Stall_Cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    ID_RS = 5'd0; ID_RT = 5'd0; ID_UsesRT = 1'b0; ID_MD = 1'b0;
    EX_MEM_RDEN = 1'b0; EX_RT = 5'd0; EX_PCSrc = 2'd0; MD_DONE = 1'b0; Stall_Clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();

    // Reset state and forced outputs
    settle();
    check("rst_pcw",   PC_Write, 0);
    check("rst_ifidw", IF_ID_Write, 0);
    check("rst_ifidf", IF_ID_Flush, 1);
    check("rst_idexf", ID_EX_Flush, 1);
    check("rst_start", MD_Start, 0);
    check("rst_busy",  MD_Busy, 0);
    check("rst_err",   MD_Error, 0);
    check("rst_stall", Stall_Cycles, 0);
    tick();
    reset = 1'b1;
    settle();
    check("run_pcw",   PC_Write, 1);
    check("run_idexf", ID_EX_Flush, 0);
    tick();

    // Load-use on RS: one bubble
    EX_MEM_RDEN = 1'b1; EX_RT = 5'd8; ID_RS = 5'd8;
    settle();
    check("lu_pcw",   PC_Write, 0);
    check("lu_ifidw", IF_ID_Write, 0);
    check("lu_idexf", ID_EX_Flush, 1);
    check("lu_ifidf", IF_ID_Flush, 0);
    tick();
    clear_inputs();
    settle();
    check("lu_after_pcw", PC_Write, 1);
    check("lu_stall",     Stall_Cycles, 1);
    tick();

    // Load to $zero never stalls
    EX_MEM_RDEN = 1'b1; EX_RT = 5'd0; ID_RS = 5'd0;
    settle();
    check("zero_pcw", PC_Write, 1);
    tick();

    // RT match only counts when RT is a source
    EX_MEM_RDEN = 1'b1; EX_RT = 5'd9; ID_RT = 5'd9; ID_RS = 5'd3; ID_UsesRT = 1'b0;
    settle();
    check("rt_nouse_pcw", PC_Write, 1);
    tick();
    ID_UsesRT = 1'b1;
    settle();
    check("rt_use_pcw", PC_Write, 0);
    tick();
    clear_inputs();
    settle();
    check("rt_stall", Stall_Cycles, 2);
    tick();

    // Redirect beats load-use and MD start
    EX_PCSrc = 2'd1; EX_MEM_RDEN = 1'b1; EX_RT = 5'd8; ID_RS = 5'd8; ID_MD = 1'b1;
    settle();
    check("redir_ifidf", IF_ID_Flush, 1);
    check("redir_idexf", ID_EX_Flush, 1);
    check("redir_pcw",   PC_Write, 1);
    check("redir_start", MD_Start, 0);
    tick();
    clear_inputs();
    settle();
    check("redir_busy",  MD_Busy, 0);
    check("redir_stall", Stall_Cycles, 2);
    tick();

    // MD with DONE on cycle 5 after start: 4 stall cycles
    ID_MD = 1'b1;
    settle();
    check("md_start", MD_Start, 1);
    check("md_pcw0",  PC_Write, 1);
    tick();
    ID_MD = 1'b0;
    settle();
    check("md_busy1",  MD_Busy, 1);
    check("md_pcw1",   PC_Write, 0);
    check("md_idexf1", ID_EX_Flush, 1);
    check("md_start1", MD_Start, 0);
    repeat (4) tick();
    MD_DONE = 1'b1;
    settle();
    check("md_done_pcw",  PC_Write, 1);
    check("md_done_flush", ID_EX_Flush, 0);
    tick();
    MD_DONE = 1'b0;
    settle();
    check("md_busy_off", MD_Busy, 0);
    check("md_stall",    Stall_Cycles, 6);
    tick();
    MD_DONE = 1'b1;
    settle();
    check("late_done_pcw", PC_Write, 1);
    tick();
    MD_DONE = 1'b0;
    settle();
    check("late_done_busy", MD_Busy, 0);
    tick();

    // Watchdog timeout after 8 MD_WAIT cycles
    ID_MD = 1'b1;
    settle();
    check("wd_start", MD_Start, 1);
    tick();
    ID_MD = 1'b0;
    repeat (7) tick();
    settle();
    check("wd_last_busy", MD_Busy, 1);
    check("wd_last_pcw",  PC_Write, 0);
    check("wd_last_err",  MD_Error, 0);
    tick();
    settle();
    check("wd_err",   MD_Error, 1);
    check("wd_busy",  MD_Busy, 0);
    check("wd_pcw",   PC_Write, 1);
    check("wd_stall", Stall_Cycles, 14);
    tick();
    settle();
    check("wd_err_pulse", MD_Error, 0);
    tick();

    // Counter saturation, then clear taking priority over an active stall
    EX_MEM_RDEN = 1'b1; EX_RT = 5'd4; ID_RS = 5'd4;
    repeat (65530) tick();
    settle();
    check("sat_ffff", Stall_Cycles, 16'hFFFF);
    repeat (3) tick();
    settle();
    check("sat_hold", Stall_Cycles, 16'hFFFF);
    tick();
    Stall_Clr = 1'b1;
    tick();
    clear_inputs();
    settle();
    check("clr_zero", Stall_Cycles, 0);
    tick();

    // Reset asserted in the middle of an MD wait
    ID_MD = 1'b1;
    tick();
    ID_MD = 1'b0;
    repeat (2) tick();
    settle();
    check("mid_busy_pre", MD_Busy, 1);
    check("mid_stall_pre", Stall_Cycles, 2);
    tick();
    reset = 1'b0;
    settle();
    check("mid_rst_busy",  MD_Busy, 0);
    check("mid_rst_stall", Stall_Cycles, 0);
    check("mid_rst_ifidf", IF_ID_Flush, 1);
    check("mid_rst_idexf", ID_EX_Flush, 1);
    check("mid_rst_pcw",   PC_Write, 0);
    tick();
    reset = 1'b1;
    settle();
    check("mid_run_pcw",   PC_Write, 1);
    check("mid_run_idexf", ID_EX_Flush, 0);
    tick();
    settle();
    check("mid_run_busy",  MD_Busy, 0);
    check("mid_run_stall", Stall_Cycles, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
